div_unit: RTL

- Iterative radix-2 restoring divider in the EX stage, beside the ALU.
- Consumes the same operand pair the ALU does: src1 = rs value (dividend), src2 = rt value (divisor).
- Produces the {HI, LO} pair for DIV/DIVU. HI holds the remainder and LO the quotient.
- Raises a stall request that holds the pipeline while the iteration runs.

---
 rtl/div_unit.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
//
// Iterative radix-2 restoring divider sitting beside the ALU in EX. It serves
// DIV (signed) and DIVU (unsigned). Operands are reduced to magnitudes at
// accept time. One quotient bit is produced per cycle, MSB first. The signs
// are re-applied in DONE, and the {remainder, quotient} pair is registered
// for the HI/LO write.
//
// Ports
//   clk               clock
//   resetn            synchronous active-low reset (sampled on rising clk)
//   div_start         divide request, only looked at in IDLE
//   div_signed        1 = DIV (two's complement), 0 = DIVU; captured at accept
//   div_cancel        pipeline flush; aborts any operation in flight
//   div_src1          dividend (rs); captured at accept
//   div_src2          divisor  (rt); captured at accept
//   div_busy          high while an operation occupies BUSY or DONE
//   div_stall_req     combinational stall request to pipeline control
//   div_result_valid  one-cycle pulse marking a freshly written div_result
//   div_result        {remainder (HI), quotient (LO)}, held until next result
// -----------------------------------------------------------------------------
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 div_start,
    input  logic                 div_signed,
    input  logic                 div_cancel,
    input  logic [WIDTH-1:0]     div_src1,
    input  logic [WIDTH-1:0]     div_src2,
    output logic                 div_busy,
    output logic                 div_stall_req,
    output logic                 div_result_valid,
    output logic [2*WIDTH-1:0]   div_result
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Two's complement negate when neg is set, pass-through otherwise.
    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v,
                                                input logic             neg);
        logic [WIDTH-1:0] r;
        if (neg) begin
            r = ~v + ONE_W;
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    // quot_q starts out holding the dividend magnitude. Dividend bits leave at
    // the top while quotient bits enter at the bottom.
    logic [WIDTH-1:0]     quot_q, quot_d;
    logic [WIDTH-1:0]     dvsr_q, dvsr_d;
    logic                 quot_neg_q, quot_neg_d;
    logic                 rem_neg_q, rem_neg_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;

    logic [WIDTH:0]       trial_shift_s;
    logic [WIDTH:0]       trial_diff_s;
    logic                 stall_s;

    // Shift-and-subtract step. The partial remainder is always below the
    // divisor, so a WIDTH+1-bit difference has its MSB set exactly when the
    // trial subtract goes negative.
    always_comb begin
        trial_shift_s = {rem_q, quot_q[WIDTH-1]};
        trial_diff_s  = trial_shift_s - {1'b0, dvsr_q};
    end

    // Next-state, datapath update and stall request.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        dvsr_d     = dvsr_q;
        quot_neg_d = quot_neg_q;
        rem_neg_d  = rem_neg_q;
        result_d   = result_q;
        valid_d    = 1'b0;
        stall_s    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (div_start && !div_cancel) begin
                    stall_s    = 1'b1;
                    state_d    = S_BUSY;
                    cnt_d      = CNT_ZERO;
                    rem_d      = ZERO_W;
                    quot_d     = neg_if(div_src1, div_signed & div_src1[WIDTH-1]);
                    dvsr_d     = neg_if(div_src2, div_signed & div_src2[WIDTH-1]);
                    quot_neg_d = div_signed & (div_src1[WIDTH-1] ^ div_src2[WIDTH-1]);
                    rem_neg_d  = div_signed & div_src1[WIDTH-1];
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                stall_s = 1'b1;
                if (div_cancel) begin
                    state_d = S_IDLE;
                end else begin
                    quot_d = {quot_q[WIDTH-2:0], ~trial_diff_s[WIDTH]};
                    if (trial_diff_s[WIDTH]) begin
                        rem_d = trial_shift_s[WIDTH-1:0];
                    end else begin
                        rem_d = trial_diff_s[WIDTH-1:0];
                    end
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                // A flush here drops the result: no pulse, HI/LO image untouched.
                if (div_cancel) begin
                    valid_d = 1'b0;
                end else begin
                    valid_d  = 1'b1;
                    result_d = {neg_if(rem_q, rem_neg_q), neg_if(quot_q, quot_neg_q)};
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_BUSY) || (state_d == S_DONE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            cnt_q      <= CNT_ZERO;
            rem_q      <= ZERO_W;
            quot_q     <= ZERO_W;
            dvsr_q     <= ZERO_W;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            result_q   <= {(2*WIDTH){1'b0}};
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            dvsr_q     <= dvsr_d;
            quot_neg_q <= quot_neg_d;
            rem_neg_q  <= rem_neg_d;
            result_q   <= result_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
        end
    end

    assign div_busy         = busy_q;
    assign div_stall_req    = stall_s;
    assign div_result_valid = valid_q;
    assign div_result       = result_q;

endmodule
